// File: rtl/pointwise_convolve_arbiter_pkg.sv
// Shared constants and types for the pointwise-convolve requester arbiter.
package pointwise_convolve_arbiter_pkg;

  localparam int DefaultNumRequesters = 2;
  localparam int DefaultMaxInFlight   = 8;
  localparam int RequesterIndexW      = $clog2(DefaultNumRequesters);

  typedef logic [RequesterIndexW-1:0] requester_index_t;

  // Round-robin successor of idx in [0, modulus).
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Tag FIFO remembering which requester owns each vector inside the convolver.
module tag_fifo
  import pointwise_convolve_arbiter_pkg::*;
#(
  parameter int Width = RequesterIndexW,
  parameter int Depth = DefaultMaxInFlight
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o     = (r_count == CntW'(Depth));
  assign empty_o    = (r_count == '0);
  assign count_o    = r_count;
  assign pop_data_o = r_mem[r_rd_ptr];
  assign w_push     = push_i && !full_o;
  assign w_pop      = pop_i && !empty_o;

  always_ff @(posedge clock_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pointwise_convolve_arbiter.sv
// Round-robin sharing of one pointwise convolver among several requesters,
// with in-order result routing through a tag FIFO.
module pointwise_convolve_arbiter
  import pointwise_convolve_arbiter_pkg::*;
#(
  parameter int InChannels      = 147,
  parameter int OutChannels     = 16,
  parameter int ActivationWidth = 8,
  parameter int NumRequesters   = DefaultNumRequesters,
  parameter int MaxInFlight     = DefaultMaxInFlight
) (
  input  logic                                              clock_i,
  input  logic                                              reset_i,
  input  logic [NumRequesters-1:0]                          req_valid_i,
  output logic [NumRequesters-1:0]                          req_ready_o,
  input  logic [NumRequesters*InChannels*ActivationWidth-1:0] req_data_i,
  output logic [NumRequesters-1:0]                          resp_valid_o,
  input  logic [NumRequesters-1:0]                          resp_ready_i,
  output logic [OutChannels*ActivationWidth-1:0]            resp_data_o,
  output logic                                              conv_valid_o,
  input  logic                                              conv_ready_i,
  output logic [InChannels*ActivationWidth-1:0]             conv_data_o,
  input  logic                                              conv_valid_i,
  output logic                                              conv_ready_o,
  input  logic [OutChannels*ActivationWidth-1:0]            conv_data_i,
  output logic [$clog2(MaxInFlight+1)-1:0]                  in_flight_o,
  output logic                                              error_o
);

  localparam int IdxW = $clog2(NumRequesters);
  localparam int VecW = InChannels * ActivationWidth;

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_lock_idx;
  logic            r_lock;
  logic            r_error;
  logic [IdxW-1:0] w_rr_idx;
  logic [IdxW-1:0] w_grant;
  logic [IdxW-1:0] w_head;
  logic            w_rr_found;
  logic            w_any_valid;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  int unsigned     w_cand;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    w_cand     = 0;
    for (int unsigned k = 0; k < NumRequesters; k++) begin
      w_cand = (32'(r_ptr) + k) % NumRequesters;
      if (!w_rr_found && req_valid_i[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IdxW'(w_cand);
      end
    end
  end

  // A stalled offer keeps its requester unless that requester withdraws.
  assign w_grant     = (r_lock && req_valid_i[r_lock_idx]) ? r_lock_idx : w_rr_idx;
  assign w_any_valid = |req_valid_i;
  assign conv_valid_o = reset_i && w_any_valid && !w_full;
  assign conv_data_o  = req_data_i[32'(w_grant)*VecW +: VecW];
  assign w_push       = conv_valid_o && conv_ready_i;

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[w_grant] = reset_i && conv_ready_i && !w_full;
  end

  assign conv_ready_o = !w_empty && resp_ready_i[w_head];
  assign w_pop        = conv_valid_i && conv_ready_o;
  assign resp_data_o  = conv_data_i;
  assign error_o      = r_error;

  always_comb begin
    resp_valid_o         = '0;
    resp_valid_o[w_head] = conv_valid_i && !w_empty;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr  <= IdxW'(next_index(32'(w_grant), NumRequesters));
        r_lock <= 1'b0;
      end else if (conv_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end else begin
        r_lock <= 1'b0;
      end
      if (conv_valid_i && w_empty) r_error <= 1'b1;
    end
  end

  tag_fifo #(
    .Width(IdxW),
    .Depth(MaxInFlight)
  ) u_tag_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .push_i     (w_push),
    .push_data_i(w_grant),
    .pop_i      (w_pop),
    .pop_data_o (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (in_flight_o)
  );

endmodule

// File: tb/tb_pointwise_convolve_arbiter.sv
// Directed bench for pointwise_convolve_arbiter; the bench plays both requesters and the convolver.
module tb_pointwise_convolve_arbiter;

  localparam int InC = 4;
  localparam int OutC = 2;
  localparam int AW = 8;
  localparam int NR = 2;
  localparam int MIF = 8;

  logic                   clock_i;
  logic                   reset_i;
  logic [NR-1:0]          req_valid_i;
  logic [NR-1:0]          req_ready_o;
  logic [NR*InC*AW-1:0]   req_data_i;
  logic [NR-1:0]          resp_valid_o;
  logic [NR-1:0]          resp_ready_i;
  logic [OutC*AW-1:0]     resp_data_o;
  logic                   conv_valid_o;
  logic                   conv_ready_i;
  logic [InC*AW-1:0]      conv_data_o;
  logic                   conv_valid_i;
  logic                   conv_ready_o;
  logic [OutC*AW-1:0]     conv_data_i;
  logic [$clog2(MIF+1)-1:0] in_flight_o;
  logic                   error_o;

  int checks = 0;
  int errors = 0;

  pointwise_convolve_arbiter #(
    .InChannels(InC), .OutChannels(OutC), .ActivationWidth(AW),
    .NumRequesters(NR), .MaxInFlight(MIF)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i), .conv_data_o(conv_data_o),
    .conv_valid_i(conv_valid_i), .conv_ready_o(conv_ready_o), .conv_data_i(conv_data_i),
    .in_flight_o(in_flight_o), .error_o(error_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic clear_inputs();
    req_valid_i = '0; req_data_i = '0; resp_ready_i = '0;
    conv_ready_i = 1'b0; conv_valid_i = 1'b0; conv_data_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    clear_inputs();
    @(posedge clock_i); @(posedge clock_i); #1;
    reset_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    req_valid_i = 2'b11; conv_ready_i = 1'b1; conv_valid_i = 1'b1; resp_ready_i = 2'b11;
    req_data_i = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    #1;
    checks++; if (conv_valid_o !== 1'b0) begin errors++; $display("FAIL reset_conv_valid: got %b want 0", conv_valid_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready_o); end
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid_o); end
    checks++; if (conv_ready_o !== 1'b0) begin errors++; $display("FAIL reset_conv_ready: got %b want 0", conv_ready_o); end
    checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL reset_in_flight: got %0d want 0", in_flight_o); end
    @(posedge clock_i); #1;
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error_o); end
    do_reset();
  endtask

  task automatic test_single_requester();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 32'h1000_0000 + 32'(i);
      req_valid_i = 2'b01; req_data_i[31:0] = d; req_data_i[63:32] = 32'hDEAD_BEEF; conv_ready_i = 1'b1;
      #1;
      checks++; if (conv_valid_o !== 1'b1) begin errors++; $display("FAIL single_conv_valid[%0d]: got %b want 1", i, conv_valid_o); end
      checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL single_grant[%0d]: got %b want 01", i, req_ready_o); end
      checks++; if (conv_data_o !== d) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, conv_data_o, d); end
      @(posedge clock_i); #1;
    end
    req_valid_i = 2'b00; conv_ready_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd3) begin errors++; $display("FAIL single_in_flight3: got %0d want 3", in_flight_o); end
    for (int i = 0; i < 3; i++) begin
      conv_valid_i = 1'b1; conv_data_i = 16'h5500 + 16'(i); resp_ready_i = 2'b11;
      #1;
      checks++; if (resp_valid_o !== 2'b01) begin errors++; $display("FAIL single_resp_valid[%0d]: got %b want 01", i, resp_valid_o); end
      checks++; if (conv_ready_o !== 1'b1) begin errors++; $display("FAIL single_conv_ready[%0d]: got %b want 1", i, conv_ready_o); end
      checks++; if (resp_data_o !== 16'h5500 + 16'(i)) begin errors++; $display("FAIL single_resp_data[%0d]: got %h want %h", i, resp_data_o, 16'h5500 + 16'(i)); end
      @(posedge clock_i); #1;
    end
    conv_valid_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL single_in_flight0: got %0d want 0", in_flight_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", error_o); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    req_data_i = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 2'b11; conv_ready_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== exp_g[i]) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", i, req_ready_o, exp_g[i]); end
      checks++; if (conv_data_o !== ((i % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1)) begin
        errors++; $display("FAIL alt_data[%0d]: got %h want %h", i, conv_data_o, (i % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
      end
      @(posedge clock_i); #1;
    end
    req_valid_i = 2'b00; conv_ready_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd4) begin errors++; $display("FAIL alt_in_flight: got %0d want 4", in_flight_o); end
    for (int i = 0; i < 4; i++) begin
      conv_valid_i = 1'b1; conv_data_i = 16'h6600 + 16'(i); resp_ready_i = 2'b11;
      #1;
      checks++; if (resp_valid_o !== exp_g[i]) begin errors++; $display("FAIL alt_route[%0d]: got %b want %b", i, resp_valid_o, exp_g[i]); end
      @(posedge clock_i); #1;
    end
    conv_valid_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL alt_drain: got %0d want 0", in_flight_o); end
  endtask

  task automatic test_stall_lock();
    do_reset();
    req_data_i = {32'h1111_2222, 32'h3333_4444};
    for (int i = 0; i < 5; i++) begin
      req_valid_i = (i >= 2) ? 2'b11 : 2'b10; conv_ready_i = 1'b0;
      #1;
      checks++; if (conv_data_o !== 32'h1111_2222) begin errors++; $display("FAIL stall_data[%0d]: got %h want 11112222", i, conv_data_o); end
      checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, req_ready_o); end
      @(posedge clock_i); #1;
    end
    conv_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL stall_accept: got %b want 10", req_ready_o); end
    @(posedge clock_i); #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL stall_next_grant: got %b want 01", req_ready_o); end
    checks++; if (conv_data_o !== 32'h3333_4444) begin errors++; $display("FAIL stall_next_data: got %h want 33334444", conv_data_o); end
    req_valid_i = 2'b00; conv_ready_i = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    req_data_i[31:0] = 32'hCAFE_0000;
    for (int i = 0; i < 8; i++) begin
      req_valid_i = 2'b01; conv_ready_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b want 01", i, req_ready_o); end
      @(posedge clock_i); #1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_flight_o !== 4'd8) begin errors++; $display("FAIL full_in_flight[%0d]: got %0d want 8", i, in_flight_o); end
      checks++; if (conv_valid_o !== 1'b0) begin errors++; $display("FAIL full_conv_valid[%0d]: got %b want 0", i, conv_valid_o); end
      checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL full_req_ready[%0d]: got %b want 00", i, req_ready_o); end
      @(posedge clock_i); #1;
    end
    conv_valid_i = 1'b1; resp_ready_i = 2'b01; conv_data_i = 16'h7070;
    #1;
    checks++; if (conv_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b want 1", conv_ready_o); end
    checks++; if (conv_valid_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle_push: got %b want 0", conv_valid_o); end
    @(posedge clock_i); #1;
    conv_valid_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd7) begin errors++; $display("FAIL full_after_pop: got %0d want 7", in_flight_o); end
    checks++; if (conv_valid_o !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", conv_valid_o); end
    req_valid_i = 2'b00; conv_ready_i = 1'b0;
  endtask

  task automatic test_resp_stall();
    do_reset();
    req_data_i[63:32] = 32'h0BAD_F00D;
    for (int i = 0; i < 2; i++) begin
      req_valid_i = 2'b10; conv_ready_i = 1'b1;
      @(posedge clock_i); #1;
    end
    req_valid_i = 2'b00; conv_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      conv_valid_i = 1'b1; conv_data_i = 16'h7777; resp_ready_i = 2'b01;
      #1;
      checks++; if (conv_ready_o !== 1'b0) begin errors++; $display("FAIL rstall_conv_ready[%0d]: got %b want 0", i, conv_ready_o); end
      checks++; if (resp_valid_o !== 2'b10) begin errors++; $display("FAIL rstall_resp_valid[%0d]: got %b want 10", i, resp_valid_o); end
      checks++; if (in_flight_o !== 4'd2) begin errors++; $display("FAIL rstall_in_flight[%0d]: got %0d want 2", i, in_flight_o); end
      @(posedge clock_i); #1;
    end
    resp_ready_i = 2'b10;
    #1;
    checks++; if (conv_ready_o !== 1'b1) begin errors++; $display("FAIL rstall_release: got %b want 1", conv_ready_o); end
    checks++; if (resp_data_o !== 16'h7777) begin errors++; $display("FAIL rstall_data0: got %h want 7777", resp_data_o); end
    @(posedge clock_i); #1;
    conv_data_i = 16'h8888;
    #1;
    checks++; if (in_flight_o !== 4'd1) begin errors++; $display("FAIL rstall_in_flight1: got %0d want 1", in_flight_o); end
    checks++; if (resp_valid_o !== 2'b10) begin errors++; $display("FAIL rstall_resp_valid2: got %b want 10", resp_valid_o); end
    checks++; if (resp_data_o !== 16'h8888) begin errors++; $display("FAIL rstall_data1: got %h want 8888", resp_data_o); end
    @(posedge clock_i); #1;
    conv_valid_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL rstall_drain: got %0d want 0", in_flight_o); end
  endtask

  task automatic test_error_and_midreset();
    do_reset();
    conv_valid_i = 1'b1; resp_ready_i = 2'b11;
    #1;
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL err_resp_valid: got %b want 00", resp_valid_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %b want 0", error_o); end
    @(posedge clock_i); #1;
    conv_valid_i = 1'b0;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", error_o); end
    for (int i = 0; i < 2; i++) begin
      req_valid_i = 2'b01; conv_ready_i = 1'b1;
      @(posedge clock_i); #1;
    end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", error_o); end
    checks++; if (in_flight_o !== 4'd2) begin errors++; $display("FAIL mid_in_flight: got %0d want 2", in_flight_o); end
    conv_valid_i = 1'b1;
    reset_i = 1'b0;
    #1;
    checks++; if (in_flight_o !== 4'd0) begin errors++; $display("FAIL mid_reset_in_flight: got %0d want 0", in_flight_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL mid_reset_error: got %b want 0", error_o); end
    checks++; if (conv_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_conv_valid: got %b want 0", conv_valid_o); end
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL mid_reset_req_ready: got %b want 00", req_ready_o); end
    checks++; if (resp_valid_o !== 2'b00) begin errors++; $display("FAIL mid_reset_resp_valid: got %b want 00", resp_valid_o); end
    checks++; if (conv_ready_o !== 1'b0) begin errors++; $display("FAIL mid_reset_conv_ready: got %b want 0", conv_ready_o); end
    do_reset();
  endtask

  initial begin
    reset_i = 1'b0;
    clear_inputs();
    test_reset();
    test_single_requester();
    test_alternate();
    test_stall_lock();
    test_full();
    test_resp_stall();
    test_error_and_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
